// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter for the integer register file write port
module regfile_wb_arbiter #(
  parameter int NREQ       = 3,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  input  logic                       hold,
  output logic                       wen,
  output logic [ADDR_WIDTH-1:0]      waddr,
  output logic [DATA_WIDTH-1:0]      wdata,
  output logic [31:0]                wr_count
);

  localparam int PTR_W = $clog2(NREQ);

  // Index of the most recently granted requester; search starts just after it.
  logic [PTR_W-1:0]      last;
  logic [NREQ-1:0]       grant;
  logic [PTR_W-1:0]      gidx;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] gaddr;
  logic [DATA_WIDTH-1:0] gdata;

  // Round-robin search from last+1; depends only on req_valid, hold, rst and last.
  always_comb begin
    int idx;
    grant = '0;
    gidx  = '0;
    xfer  = 1'b0;
    idx   = 0;
    if (!rst && !hold) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (int'(last) + k) % NREQ;
        if (!xfer && req_valid[idx]) begin
          grant[idx] = 1'b1;
          gidx       = PTR_W'(idx);
          xfer       = 1'b1;
        end
      end
    end
  end

  assign req_ready = grant;

  // Select the winning requester's payload for the output register.
  always_comb begin
    gaddr = req_addr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
    gdata = req_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Pointer, registered write port and commit counter; x0 writes load but never enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last     <= PTR_W'(NREQ - 1);
      wen      <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      wr_count <= '0;
    end else if (xfer) begin
      last  <= gidx;
      wen   <= (gaddr != '0);
      waddr <= gaddr;
      wdata <= gdata;
      if (gaddr != '0) begin
        wr_count <= wr_count + 32'd1;
      end
    end else begin
      wen <= 1'b0;
    end
  end

endmodule
